// File: rtl/fcsr_pkg.sv
// Shared constants and types for the FP control/status register block.
package fcsr_pkg;

   localparam logic [11:0] CSR_FFLAGS = 12'h001;
   localparam logic [11:0] CSR_FRM    = 12'h002;
   localparam logic [11:0] CSR_FCSR   = 12'h003;

   localparam int FFLAGS_LSB = 0;
   localparam int FRM_LSB    = 5;

   typedef enum logic [1:0] {
      CSR_READ = 2'd0,
      CSR_RW   = 2'd1,
      CSR_RS   = 2'd2,
      CSR_RC   = 2'd3
   } csr_mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      EXEC  = 2'd2
   } state_e;

endpackage

// File: rtl/fcsr_field_update.sv
// Combinational old-value select and read-modify-write ALU for one fcsr access.
module fcsr_field_update
   import fcsr_pkg::*;
(
   input  logic [11:0] addr_i,
   input  logic [1:0]  mode_i,
   input  logic [31:0] wdata_i,
   input  logic [4:0]  fflags_i,
   input  logic [2:0]  frm_i,
   output logic [31:0] old_o,
   output logic [31:0] new_o,
   output logic        legal_o
);

   always_comb begin
      old_o   = '0;
      legal_o = 1'b1;
      case (addr_i)
         CSR_FFLAGS: old_o[4:0] = fflags_i;
         CSR_FRM:    old_o[2:0] = frm_i;
         CSR_FCSR:   old_o[7:0] = {frm_i, fflags_i};
         default:    legal_o    = 1'b0;
      endcase
   end

   always_comb begin
      new_o = old_o;
      case (csr_mode_e'(mode_i))
         CSR_RW:  new_o = wdata_i;
         CSR_RS:  new_o = old_o | wdata_i;
         CSR_RC:  new_o = old_o & ~wdata_i;
         default: new_o = old_o;
      endcase
   end

endmodule

// File: rtl/fcsr_ctrl.sv
// fcsr owner: sticky flag accumulation, outstanding-op drain and serialised CSR access.
//  state | meaning
//  IDLE  | no CSR access in progress; FP issue allowed unless counter full
//  DRAIN | CSR request waiting for all in-flight FP ops to retire
//  EXEC  | single-cycle read-modify-write of the addressed field
module fcsr_ctrl
   import fcsr_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4,
   parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fp_issue,
   input  logic        fp_done,
   input  logic [4:0]  f_flags,
   output logic        fp_stall,
   input  logic        csr_req,
   input  logic [11:0] csr_addr,
   input  logic [1:0]  csr_mode,
   input  logic [31:0] csr_wdata,
   output logic        csr_ready,
   output logic [31:0] csr_rdata,
   output logic        csr_illegal,
   output logic [2:0]  frm,
   output logic [31:0] fcsr_out
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [4:0]         fflags_q, fflags_d;
   logic [2:0]         frm_q, frm_d;
   logic               ready_q, ready_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               illegal_q, illegal_d;
   logic               exec;

   logic [31:0]        old_val;
   logic [31:0]        new_val;
   logic               legal;
   logic               unused_new_hi;

   fcsr_field_update u_field_update (
      .addr_i   (csr_addr),
      .mode_i   (csr_mode),
      .wdata_i  (csr_wdata),
      .fflags_i (fflags_q),
      .frm_i    (frm_q),
      .old_o    (old_val),
      .new_o    (new_val),
      .legal_o  (legal)
   );

   assign unused_new_hi = ^new_val[31:8];

   // Stall combinationally on csr_req so nothing issues in the request cycle.
   assign fp_stall = (count_q == CNT_W'(MAX_OUTSTANDING)) || (state_q != IDLE) || csr_req;

   always_comb begin
      count_d = count_q;
      case ({fp_issue, fp_done})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      exec    = 1'b0;
      case (state_q)
         IDLE: begin
            if (csr_req) begin
               state_d = ((count_q != '0) || fp_done) ? DRAIN : EXEC;
            end
         end
         DRAIN: begin
            if ((count_q == '0) && !fp_done) begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            exec    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      fflags_d  = fp_done ? (fflags_q | f_flags) : fflags_q;
      frm_d     = frm_q;
      ready_d   = exec;
      rdata_d   = exec ? old_val : rdata_q;
      illegal_d = exec ? !legal : illegal_q;
      if (exec && legal) begin
         case (csr_addr)
            CSR_FFLAGS: fflags_d = new_val[4:0];
            CSR_FRM:    frm_d    = new_val[2:0];
            CSR_FCSR: begin
               fflags_d = new_val[FRM_LSB-1:FFLAGS_LSB];
               frm_d    = new_val[FRM_LSB+2:FRM_LSB];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         count_q   <= '0;
         fflags_q  <= '0;
         frm_q     <= '0;
         ready_q   <= 1'b0;
         rdata_q   <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         fflags_q  <= fflags_d;
         frm_q     <= frm_d;
         ready_q   <= ready_d;
         rdata_q   <= rdata_d;
         illegal_q <= illegal_d;
      end
   end

   assign csr_ready   = ready_q;
   assign csr_rdata   = rdata_q;
   assign csr_illegal = illegal_q;
   assign frm         = frm_q;
   assign fcsr_out    = {24'b0, frm_q, fflags_q};

endmodule

// File: tb/tb_fcsr_ctrl.sv
// Directed bench for fcsr_ctrl: drain, RMW modes, illegal address, stall and reset abort.
module tb_fcsr_ctrl;
   import fcsr_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        fp_issue;
   logic        fp_done;
   logic [4:0]  f_flags;
   logic        fp_stall;
   logic        csr_req;
   logic [11:0] csr_addr;
   logic [1:0]  csr_mode;
   logic [31:0] csr_wdata;
   logic        csr_ready;
   logic [31:0] csr_rdata;
   logic        csr_illegal;
   logic [2:0]  frm;
   logic [31:0] fcsr_out;

   int passed = 0;
   int total  = 0;
   int tb_cnt;

   always #5 clk = ~clk;

   fcsr_ctrl #(.MAX_OUTSTANDING(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .fp_issue    (fp_issue),
      .fp_done     (fp_done),
      .f_flags     (f_flags),
      .fp_stall    (fp_stall),
      .csr_req     (csr_req),
      .csr_addr    (csr_addr),
      .csr_mode    (csr_mode),
      .csr_wdata   (csr_wdata),
      .csr_ready   (csr_ready),
      .csr_rdata   (csr_rdata),
      .csr_illegal (csr_illegal),
      .frm         (frm),
      .fcsr_out    (fcsr_out)
   );

   // Bench-side protocol guard: the stimulus itself must respect the handshake.
   always @(posedge clk) begin
      if (rst) begin
         tb_cnt <= 0;
      end else begin
         assert (!(fp_issue && fp_stall)) else $error("protocol: fp_issue while fp_stall");
         assert (!(fp_done && tb_cnt == 0)) else $error("protocol: fp_done with nothing outstanding");
         tb_cnt <= tb_cnt + int'(fp_issue) - int'(fp_done);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_csr(input logic [11:0] a, input logic [1:0] m, input logic [31:0] wd,
                         output logic [31:0] rd, output logic ill, output int lat);
      csr_req   = 1'b1;
      csr_addr  = a;
      csr_mode  = m;
      csr_wdata = wd;
      lat       = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (csr_ready) begin
            lat = i;
            break;
         end
      end
      rd      = csr_rdata;
      ill     = csr_illegal;
      csr_req = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; fp_issue = 1'b0; fp_done = 1'b0; f_flags = '0;
      csr_req = 1'b0; csr_addr = '0; csr_mode = '0; csr_wdata = '0;
      tick(); tick();
      if (fcsr_out !== 32'h0) $display("FAIL reset_fcsr: got %h want %h", fcsr_out, 32'h0); else passed++;
      total++;
      if ({csr_ready, csr_illegal, frm} !== 5'b0) $display("FAIL reset_ctl: got %b want %b", {csr_ready, csr_illegal, frm}, 5'b0); else passed++;
      total++;
      if (csr_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want %h", csr_rdata, 32'h0); else passed++;
      total++;
      rst = 1'b0;
      tick();
      if (fp_stall !== 1'b0) $display("FAIL reset_stall: got %b want %b", fp_stall, 1'b0); else passed++;
      total++;
   endtask

   task automatic test_read_idle();
      int lat;
      csr_req = 1'b1; csr_addr = CSR_FCSR; csr_mode = CSR_READ; csr_wdata = 32'hFFFF_FFFF;
      #1;
      if (fp_stall !== 1'b1) $display("FAIL idle_req_stall: got %b want %b", fp_stall, 1'b1); else passed++;
      total++;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (csr_ready) begin lat = i; break; end
      end
      if (lat !== 2) $display("FAIL idle_latency: got %0d want %0d", lat, 2); else passed++;
      total++;
      if ({csr_rdata, csr_illegal} !== 33'h0) $display("FAIL idle_read: got %h/%b want 0/0", csr_rdata, csr_illegal); else passed++;
      total++;
      csr_req = 1'b0;
      tick();
      if (fcsr_out !== 32'h0) $display("FAIL idle_read_nowrite: got %h want %h", fcsr_out, 32'h0); else passed++;
      total++;
   endtask

   task automatic test_drain();
      logic       done_pat [5];
      logic [4:0] flag_pat [5];
      logic       early_ready;
      logic       stall_low;
      int         lat;
      done_pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      flag_pat = '{5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b10000};
      fp_issue = 1'b1; tick(); tick(); fp_issue = 1'b0;
      csr_req = 1'b1; csr_addr = CSR_FFLAGS; csr_mode = CSR_READ; csr_wdata = '0;
      early_ready = 1'b0;
      stall_low   = 1'b0;
      for (int i = 0; i < 5; i++) begin
         fp_done = done_pat[i];
         f_flags = flag_pat[i];
         #1;
         if (!fp_stall) stall_low = 1'b1;
         tick();
         if (csr_ready) early_ready = 1'b1;
      end
      fp_done = 1'b0; f_flags = '0;
      lat = -1;
      for (int i = 1; i <= 10; i++) begin
         if (!fp_stall) stall_low = 1'b1;
         tick();
         if (csr_ready) begin lat = i; break; end
      end
      if (early_ready !== 1'b0) $display("FAIL drain_early_ready: got %b want %b", early_ready, 1'b0); else passed++;
      total++;
      if (lat < 1) $display("FAIL drain_timeout: got %0d want >=1", lat); else passed++;
      total++;
      if (stall_low !== 1'b0) $display("FAIL drain_stall: got low=%b want low=%b", stall_low, 1'b0); else passed++;
      total++;
      if (csr_rdata !== 32'h11) $display("FAIL drain_rdata: got %h want %h", csr_rdata, 32'h11); else passed++;
      total++;
      csr_req = 1'b0;
      tick();
   endtask

   task automatic test_frm_write();
      logic [31:0] rd;
      logic        ill;
      int          lat;
      do_csr(CSR_FFLAGS, CSR_RW, 32'h0000_001F, rd, ill, lat);
      if (rd !== 32'h11) $display("FAIL fflags_rw_old: got %h want %h", rd, 32'h11); else passed++;
      total++;
      if (fcsr_out !== 32'h1F) $display("FAIL fflags_rw_new: got %h want %h", fcsr_out, 32'h1F); else passed++;
      total++;
      do_csr(CSR_FRM, CSR_RW, 32'hFFFF_FFFB, rd, ill, lat);
      if ({rd, ill} !== 33'h0) $display("FAIL frm_rw_old: got %h/%b want 0/0", rd, ill); else passed++;
      total++;
      if (frm !== 3'b011) $display("FAIL frm_rw_frm: got %b want %b", frm, 3'b011); else passed++;
      total++;
      if (fcsr_out !== 32'h7F) $display("FAIL frm_rw_fcsr: got %h want %h", fcsr_out, 32'h7F); else passed++;
      total++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd;
      logic        ill;
      int          lat;
      do_csr(CSR_FCSR, CSR_RC, 32'h0000_0005, rd, ill, lat);
      if (rd !== 32'h7F) $display("FAIL rc_old: got %h want %h", rd, 32'h7F); else passed++;
      total++;
      if (fcsr_out !== 32'h7A) $display("FAIL rc_new: got %h want %h", fcsr_out, 32'h7A); else passed++;
      total++;
      do_csr(CSR_FCSR, CSR_RS, 32'h0000_0100, rd, ill, lat);
      if (rd !== 32'h7A) $display("FAIL rs_old: got %h want %h", rd, 32'h7A); else passed++;
      total++;
      if (fcsr_out !== 32'h7A) $display("FAIL rs_hi_ignored: got %h want %h", fcsr_out, 32'h7A); else passed++;
      total++;
      do_csr(CSR_FRM, CSR_READ, 32'hFFFF_FFFF, rd, ill, lat);
      if (rd !== 32'h3) $display("FAIL frm_read: got %h want %h", rd, 32'h3); else passed++;
      total++;
   endtask

   task automatic test_illegal();
      logic [31:0] rd;
      logic        ill;
      int          lat;
      do_csr(12'h300, CSR_RW, 32'hFFFF_FFFF, rd, ill, lat);
      if (ill !== 1'b1) $display("FAIL illegal_flag: got %b want %b", ill, 1'b1); else passed++;
      total++;
      if (rd !== 32'h0) $display("FAIL illegal_rdata: got %h want %h", rd, 32'h0); else passed++;
      total++;
      if (fcsr_out !== 32'h7A) $display("FAIL illegal_nowrite: got %h want %h", fcsr_out, 32'h7A); else passed++;
      total++;
      do_csr(CSR_FCSR, CSR_READ, 32'h0, rd, ill, lat);
      if ({rd, ill} !== {32'h7A, 1'b0}) $display("FAIL legal_after_illegal: got %h/%b want 7a/0", rd, ill); else passed++;
      total++;
   endtask

   task automatic test_fill();
      fp_issue = 1'b1; tick(); tick(); tick();
      if (fp_stall !== 1'b0) $display("FAIL fill_three: got %b want %b", fp_stall, 1'b0); else passed++;
      total++;
      fp_done = 1'b1; f_flags = 5'b00000; tick();
      if (fp_stall !== 1'b0) $display("FAIL fill_issue_done: got %b want %b", fp_stall, 1'b0); else passed++;
      total++;
      fp_done = 1'b0; tick(); fp_issue = 1'b0; #1;
      if (fp_stall !== 1'b1) $display("FAIL fill_full: got %b want %b", fp_stall, 1'b1); else passed++;
      total++;
      fp_done = 1'b1; tick();
      if (fp_stall !== 1'b0) $display("FAIL fill_release: got %b want %b", fp_stall, 1'b0); else passed++;
      total++;
      tick(); tick();
      f_flags = 5'b00100; tick();
      fp_done = 1'b0; f_flags = '0; tick();
      if (fcsr_out !== 32'h7E) $display("FAIL fill_flags: got %h want %h", fcsr_out, 32'h7E); else passed++;
      total++;
   endtask

   task automatic test_reset_drain();
      logic saw_ready;
      fp_issue = 1'b1; tick(); fp_issue = 1'b0;
      csr_req = 1'b1; csr_addr = CSR_FCSR; csr_mode = CSR_RW; csr_wdata = 32'hFF;
      tick(); tick();
      rst = 1'b1; fp_done = 1'b1; f_flags = 5'h1F; csr_req = 1'b0;
      tick();
      rst = 1'b0; fp_done = 1'b0; f_flags = '0;
      #1;
      if (fcsr_out !== 32'h0) $display("FAIL rst_drain_fcsr: got %h want %h", fcsr_out, 32'h0); else passed++;
      total++;
      if ({fp_stall, csr_ready, csr_illegal} !== 3'b0) $display("FAIL rst_drain_ctl: got %b want %b", {fp_stall, csr_ready, csr_illegal}, 3'b0); else passed++;
      total++;
      if (csr_rdata !== 32'h0) $display("FAIL rst_drain_rdata: got %h want %h", csr_rdata, 32'h0); else passed++;
      total++;
      saw_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (csr_ready) saw_ready = 1'b1;
      end
      if (saw_ready !== 1'b0) $display("FAIL rst_drain_no_ready: got %b want %b", saw_ready, 1'b0); else passed++;
      total++;
      if (fcsr_out !== 32'h0) $display("FAIL rst_drain_nowrite: got %h want %h", fcsr_out, 32'h0); else passed++;
      total++;
   endtask

   initial begin
      test_reset();
      test_read_idle();
      test_drain();
      test_frm_write();
      test_back_to_back();
      test_illegal();
      test_fill();
      test_reset_drain();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout want finish");
      $fatal(1, "bench did not finish");
   end

endmodule
